// File: rtl/ram1_uart_bus_ctrl_pkg.sv
// Shared definitions for the Ram1 bus controller: state encoding, UART register
// addresses, status-word bit positions and the per-state strobe decode.
package ram1_uart_bus_ctrl_pkg;

  localparam logic [15:0] DEF_UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] DEF_UART_STAT_ADDR = 16'hBF01;

  localparam int STAT_TX_READY_BIT = 0;
  localparam int STAT_RX_READY_BIT = 1;

  typedef enum logic [3:0] {
    IDLE, SR1, SR2, SW1, SW2, SW3, UR1, UR2, UW1, UW2, STAT, DONE
  } state_t;

  // Every registered bus-side control bit; strobes are active-low.
  typedef struct packed {
    logic ram1_en_n;
    logic ram1_oe_n;
    logic ram1_we_n;
    logic rdn;
    logic wrn;
    logic drive_en;
    logic ack;
    logic busy;
  } bus_ctl_t;

  localparam bus_ctl_t CTL_IDLE = '{
    ram1_en_n: 1'b1, ram1_oe_n: 1'b1, ram1_we_n: 1'b1, rdn: 1'b1, wrn: 1'b1,
    drive_en: 1'b0, ack: 1'b0, busy: 1'b0
  };

  // Control levels that must be on the pins while the FSM sits in state s.
  function automatic bus_ctl_t decode_ctl(input state_t s);
    bus_ctl_t c;
    c      = CTL_IDLE;
    c.busy = (s != IDLE);
    case (s)
      SR1, SR2: begin
        c.ram1_en_n = 1'b0;
        c.ram1_oe_n = 1'b0;
      end
      SW1, SW3: begin
        c.ram1_en_n = 1'b0;
        c.drive_en  = 1'b1;
      end
      SW2: begin
        c.ram1_en_n = 1'b0;
        c.ram1_we_n = 1'b0;
        c.drive_en  = 1'b1;
      end
      UR1, UR2: c.rdn = 1'b0;
      UW1: begin
        c.wrn      = 1'b0;
        c.drive_en = 1'b1;
      end
      UW2:  c.drive_en = 1'b1;
      DONE: c.ack      = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram1_uart_bus_ctrl.sv
// Sequences MEM-stage loads/stores onto the shared Ram1 bus (data SRAM + UART),
// with registered strobes, an owned tristate data bus and a one-cycle ack.
module ram1_uart_bus_ctrl
  import ram1_uart_bus_ctrl_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        wrn,
  output logic        rdn
);

  state_t      state, next_state;
  bus_ctl_t    ctl, ctl_next;
  logic [15:0] bus_out;
  logic [15:0] stat_word;
  logic        drive_en;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (addr == UART_STAT_ADDR)      next_state = STAT;
          else if (addr == UART_DATA_ADDR) next_state = we ? UW1 : UR1;
          else                             next_state = we ? SW1 : SR1;
        end
      end
      SR1:     next_state = SR2;
      SR2:     next_state = DONE;
      SW1:     next_state = SW2;
      SW2:     next_state = SW3;
      SW3:     next_state = DONE;
      UR1:     next_state = UR2;
      UR2:     next_state = DONE;
      UW1:     next_state = UW2;
      UW2:     next_state = DONE;
      STAT:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: strobes are decoded from next_state and registered, so each pin
  // changes exactly on the edge that enters its state and never glitches.
  assign ctl_next = decode_ctl(next_state);

  always_comb begin
    stat_word                    = '0;
    stat_word[STAT_RX_READY_BIT] = data_ready;
    stat_word[STAT_TX_READY_BIT] = tbre & tsre;
  end

  // NOTE: all state here is updated with <= so every register samples the
  // pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ctl      <= CTL_IDLE;
      bus_out  <= '0;
      rdata    <= '0;
      Ram1Addr <= '0;
    end else begin
      state <= next_state;
      ctl   <= ctl_next;
      if (state == IDLE && req) begin
        Ram1Addr <= {2'b00, addr};
        bus_out  <= (addr == UART_DATA_ADDR) ? {8'h00, wdata[7:0]} : wdata;
      end
      // Read data is captured on the edge that leaves the last data phase.
      case (state)
        SR2:     rdata <= Ram1Data;
        UR2:     rdata <= {8'h00, Ram1Data[7:0]};
        STAT:    rdata <= stat_word;
        default: ;
      endcase
    end
  end

  assign drive_en = ctl.drive_en;
  assign Ram1Data = drive_en ? bus_out : {16{1'bz}};

  assign Ram1EN = ctl.ram1_en_n;
  assign Ram1OE = ctl.ram1_oe_n;
  assign Ram1WE = ctl.ram1_we_n;
  assign rdn    = ctl.rdn;
  assign wrn    = ctl.wrn;
  assign ack    = ctl.ack;
  assign busy   = ctl.busy;

endmodule
